// File: rtl/alu_pipe.sv
// Handshaked pipelined ALU: single-cycle logic/add ops, optional shift-add MUL on opcode 111.
// Define ALU_PIPE_MUL_EN to build the multiplier; without it opcode 111 passes A through.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [2:0]       ALU_OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             SKZ_cmp,
    output logic             carry
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_zero;
    logic [WIDTH:0]   add_sum;

    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign add_sum   = {1'b0, inA} + {1'b0, inB};

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      step_cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_next;

    assign is_mul   = (ALU_OP == 3'b111);
    assign mul_last = (state == BUSY) && (step_cnt == CW'(WIDTH - 1));

    // Upper half accumulates the partial product while the multiplier shifts out of the lower half.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_next = {mul_sum, prod[WIDTH-1:1]};
    end
`else
    assign is_mul   = 1'b0;
    assign mul_last = 1'b0;
`endif

    // Opcodes 000, 001, 110 and a disabled 111 return A, so the zero flag of the result equals NOR(A).
    always_comb begin
        alu_res   = inA;
        alu_carry = 1'b0;
        case (ALU_OP)
            3'b101:  alu_res = inB;
            3'b011:  alu_res = inA & inB;
            3'b100:  alu_res = inA ^ inB;
            3'b010: begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
            end
            default: alu_res = inA;
        endcase
        alu_zero = ~|alu_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = is_mul ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (mul_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    next_state = is_mul ? BUSY : DONE;
                end else if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            SKZ_cmp <= 1'b0;
            carry   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            mcand    <= '0;
            prod     <= '0;
            step_cnt <= '0;
`endif
        end else begin
            if (accept && !is_mul) begin
                result  <= alu_res;
                SKZ_cmp <= alu_zero;
                carry   <= alu_carry;
            end
`ifdef ALU_PIPE_MUL_EN
            if (accept && is_mul) begin
                mcand    <= inA;
                prod     <= {{WIDTH{1'b0}}, inB};
                step_cnt <= '0;
            end else if (state == BUSY) begin
                prod     <= prod_next;
                step_cnt <= step_cnt + CW'(1);
                if (mul_last) begin
                    result  <= prod_next[WIDTH-1:0];
                    SKZ_cmp <= ~|prod_next[WIDTH-1:0];
                    carry   <= |prod_next[2*WIDTH-1:WIDTH];
                end
            end
`endif
        end
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; SHALL be legal for any value 4..32.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  operand/opcode presented this cycle.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 inA  input  WIDTH  accumulator operand.
REQ-007 inB  input  WIDTH  memory operand.
REQ-008 ALU_OP  input  3  opcode.
REQ-009 out_valid  output  1  result, zero and carry outputs are valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  WIDTH  registered result.
REQ-012 SKZ_cmp  output  1  registered zero flag.
REQ-013 carry  output  1  registered carry/overflow flag.

Function
REQ-014 Operation accepted on a rising edge where in_valid and in_ready are both 1; inA, inB and ALU_OP SHALL be latched then and ignored afterwards.
REQ-015 Opcode map: 110 result=A; 101 result=B; 011 A AND B; 100 A XOR B; 010 A+B mod 2^WIDTH; 000, 001 and any disabled opcode result=A.
REQ-016 carry SHALL be the adder carry-out for 010, the OR of product bits [2*WIDTH-1:WIDTH] for 111 (MUL), and 0 for all other opcodes.
REQ-017 SKZ_cmp SHALL be NOR of latched A for opcodes 000, 001, 110 and for 111 when MUL is compiled out; otherwise NOR of result.
REQ-018 FSM states IDLE, BUSY, DONE; IDLE->DONE on accept of a single-cycle opcode; IDLE->BUSY on accept of MUL; BUSY->DONE after the final multiply step; DONE->IDLE on out_ready with no new accept; DONE->DONE or DONE->BUSY on out_ready with a simultaneous accept.
REQ-019 Single-cycle latency: out_valid SHALL be 1 the cycle after accept.
REQ-020 MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles in BUSY; out_valid SHALL be 1 WIDTH+1 cycles after accept.
REQ-021 in_ready = (state==IDLE) OR (state==DONE AND out_ready); in_ready SHALL be 0 in BUSY.
REQ-022 out_valid = (state==DONE); result, SKZ_cmp and carry SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous drain and accept in DONE SHALL yield back-to-back single-cycle results with no bubble.
REQ-024 in_valid while in_ready=0 SHALL be ignored, no state change.

Reset
REQ-025 rst=1 on a rising edge SHALL force IDLE, result=0, SKZ_cmp=0, carry=0, out_valid=0, discard any latched operands and multiply progress.
REQ-026 in_ready SHALL read 0 while rst is sampled high and 1 the first cycle after rst deasserts.
REQ-027 Reset asserted mid-MUL or in DONE with out_ready=0 SHALL abort the operation; no result for it is ever presented.

Configuration
REQ-028 Macro ALU_PIPE_MUL_EN: defined -> opcode 111 is MUL per REQ-016/REQ-020 with BUSY state and multiply datapath present.
REQ-029 Without ALU_PIPE_MUL_EN: opcode 111 is single-cycle result=A, carry=0, SKZ_cmp=NOR(A); BUSY state never entered; no multiplier logic synthesised.

Verification (WIDTH=8)
REQ-030 Accept ADD A=0xF0 B=0x20 -> next cycle out_valid=1, result=0x10, carry=1, SKZ_cmp=0.
REQ-031 Accept XOR A=0x5A B=0x5A -> result=0x00, SKZ_cmp=1; then STO A=0x00 B=0xFF -> result=0x00, SKZ_cmp=1 (from A).
REQ-032 MUL_EN defined, MUL A=0x10 B=0x11 -> in_ready=0 for 8 cycles, out_valid on cycle 9, result=0x10, carry=1.
REQ-033 Hold out_ready=0 for 5 cycles after AND A=0xCC B=0x0F -> result=0x0C stable, in_ready=0; then out_ready=1 with new LDA B=0x80 -> next cycle result=0x80, no bubble.
REQ-034 rst asserted 3 cycles into MUL -> next cycle out_valid=0, result=0, in_ready=1 after rst drops; no stale result appears.
REQ-035 MUL_EN undefined, opcode 111 A=0x00 B=0x07 -> result=0x00, SKZ_cmp=1, carry=0, latency 1 cycle.
